// File: rtl/i2s_rx_slave.sv
// Slave-mode I2S receiver: oversamples SCK/WS/SD, deserializes MSB-first stereo words
// (Philips or left-justified) and queues {left,right} pairs in a FWFT FIFO.
module i2s_rx_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          fmt_i,
    input  logic [1:0]                    wdlen_i,
    input  logic                          i2s_sck_i,
    input  logic                          i2s_ws_i,
    input  logic                          i2s_sd_i,
    output logic                          rx_valid_o,
    input  logic                          rx_ready_i,
    output logic [DATA_WIDTH-1:0]         rx_ldat_o,
    output logic [DATA_WIDTH-1:0]         rx_rdat_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic                          sync_o,
    output logic                          ovf_o
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HUNT, LEFT, RIGHT} state_t;

    function automatic logic [CW-1:0] wlen_f(input logic [1:0] wd);
        int w;
        w = (int'(wd) + 1) * 8;
        if (w > DATA_WIDTH) w = DATA_WIDTH;
        return CW'(w);
    endfunction

    logic sck_s1_q, sck_s_q, sck_sd_q, ws_s1_q, ws_s_q, sd_s1_q, sd_s_q;
    logic ws_prev_q, pend_q;
    logic [DATA_WIDTH-1:0] cur_q, cur_d, left_q, push_l_q, push_r_q;
    logic [CW-1:0] cnt_q, cnt_d, wlen, idx;
    state_t state_q;
    logic sync_q, push_q, ovf_q;
    logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] fcnt_q;
    logic sck_rise, ws_chg, boundary, full, pop, wr_en;

    assign sck_rise = sck_s_q & ~sck_sd_q;
    assign ws_chg   = ws_s_q ^ ws_prev_q;
    // Philips closes a channel one SCK after WS toggles; LJ closes on the toggle itself
    assign boundary = sck_rise & (fmt_i ? ws_chg : pend_q);
    assign wlen     = wlen_f(wdlen_i);
    assign idx      = wlen - CW'(1) - cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            {sck_s1_q, sck_s_q, sck_sd_q} <= '0;
            {ws_s1_q, ws_s_q, sd_s1_q, sd_s_q} <= '0;
            ws_prev_q <= 1'b0;
            pend_q    <= 1'b0;
            cur_q     <= '0;
            cnt_q     <= '0;
        end else begin
            sck_s1_q <= i2s_sck_i;
            sck_s_q  <= sck_s1_q;
            sck_sd_q <= sck_s_q;
            ws_s1_q  <= i2s_ws_i;
            ws_s_q   <= ws_s1_q;
            sd_s1_q  <= i2s_sd_i;
            sd_s_q   <= sd_s1_q;
            if (sck_rise) begin
                ws_prev_q <= ws_s_q;
                pend_q    <= ~fmt_i & ws_chg;
            end
            cur_q <= cur_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cur_d = cur_q;
        cnt_d = cnt_q;
        if (!en_i) begin
            cur_d = '0;
            cnt_d = '0;
        end else if (boundary) begin
            cur_d = {{(DATA_WIDTH-1){1'b0}}, sd_s_q} << (wlen - CW'(1));
            cnt_d = CW'(1);
        end else if (sck_rise && (cnt_q < wlen)) begin
            cur_d = cur_q | ({{(DATA_WIDTH-1){1'b0}}, sd_s_q} << idx);
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sync_q   <= 1'b0;
            left_q   <= '0;
            push_q   <= 1'b0;
            push_l_q <= '0;
            push_r_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (!en_i) begin
                state_q <= IDLE;
                sync_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: state_q <= HUNT;
                    HUNT: if (boundary && !ws_s_q) begin
                        state_q <= LEFT;
                        sync_q  <= 1'b1;
                    end
                    LEFT: if (boundary) begin
                        left_q  <= cur_q;
                        state_q <= RIGHT;
                    end
                    RIGHT: if (boundary) begin
                        push_q   <= 1'b1;
                        push_l_q <= left_q;
                        push_r_q <= cur_q;
                        state_q  <= LEFT;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign full  = (fcnt_q == (AW+1)'(FIFO_DEPTH));
    assign pop   = (fcnt_q != '0) & rx_ready_i;
    assign wr_en = push_q & (~full | pop);

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= {push_l_q, push_r_q};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            ovf_q <= push_q & ~wr_en;
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, pop})
                2'b10:   fcnt_q <= fcnt_q + (AW+1)'(1);
                2'b01:   fcnt_q <= fcnt_q - (AW+1)'(1);
                default: fcnt_q <= fcnt_q;
            endcase
        end
    end

    // Head data is masked when empty so outputs read 0 out of reset
    assign rx_valid_o = (fcnt_q != '0);
    assign rx_ldat_o  = rx_valid_o ? mem_q[rd_ptr_q][2*DATA_WIDTH-1:DATA_WIDTH] : '0;
    assign rx_rdat_o  = rx_valid_o ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
    assign fifo_cnt_o = fcnt_q;
    assign sync_o     = sync_q;
    assign ovf_o      = ovf_q;
endmodule

// File: tb/tb_i2s_rx_slave.sv
// Directed bench for i2s_rx_slave: a bit-level I2S master model, a table of frame
// formats with hand-computed words, and sequences for overflow, simultaneous pop and enable/reset.
module tb_i2s_rx_slave;
    localparam int DW = 32;
    localparam int FD = 4;

    logic clk = 1'b0;
    logic rst, en, fmt, sck, ws, sd, ready;
    logic [1:0] wdlen;
    logic rx_valid, sync, ovf;
    logic [DW-1:0] ldat, rdat;
    logic [2:0] fcnt;

    int errors = 0;
    int checks = 0;
    int ovf_total = 0;

    i2s_rx_slave #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .fmt_i(fmt), .wdlen_i(wdlen),
        .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sd_i(sd),
        .rx_valid_o(rx_valid), .rx_ready_i(ready), .rx_ldat_o(ldat), .rx_rdat_o(rdat),
        .fifo_cnt_o(fcnt), .sync_o(sync), .ovf_o(ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (ovf) ovf_total <= ovf_total + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        f;
        logic [1:0]  wd;
        int          n;
        int          dn;
        logic [31:0] l;
        logic [31:0] r;
        logic [31:0] el;
        logic [31:0] er;
    } vec_t;

    vec_t vt [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCK period: master drives WS/SD after the falling edge, receiver samples at the rise
    task automatic slot(input logic w, input logic d);
        @(posedge clk); #1 sck = 1'b0; ws = w; sd = d;
        repeat (4) @(posedge clk);
        #1 sck = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic frame_part(input logic f, input int n, input int dn,
                              input logic [31:0] lw, input logic [31:0] rw,
                              input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            int p;
            logic [31:0] word;
            logic w, d;
            p    = k % n;
            word = (k < n) ? lw : rw;
            d    = (p < dn) ? word[dn-1-p] : 1'b1;
            w    = f ? (k >= n) : (((k + 1) % (2 * n)) >= n);
            slot(w, d);
        end
    endtask

    task automatic frame(input logic f, input int n, input int dn,
                         input logic [31:0] lw, input logic [31:0] rw);
        frame_part(f, n, dn, lw, rw, 0, 2 * n);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1; en = 1'b0; ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pop_chk(input string nm, input logic [31:0] el, input logic [31:0] er);
        chk({nm, "_valid"}, 64'(rx_valid), 64'd1);
        chk({nm, "_ldat"}, 64'(ldat), 64'(el));
        chk({nm, "_rdat"}, 64'(rdat), 64'(er));
        @(posedge clk); #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
    endtask

    initial begin
        int o0;
        rst = 1'b0; en = 1'b0; fmt = 1'b0; wdlen = 2'd1;
        sck = 1'b1; ws = 1'b0; sd = 1'b0; ready = 1'b0;

        vt[0] = '{1'b0, 2'd1, 16, 16, 32'hA5C3, 32'h3C5A, 32'h0000A5C3, 32'h00003C5A};
        vt[1] = '{1'b1, 2'd3, 32, 32, 32'h80000001, 32'hFFFF0000, 32'h80000001, 32'hFFFF0000};
        vt[2] = '{1'b0, 2'd0, 16, 8, 32'h96, 32'h5A, 32'h00000096, 32'h0000005A};
        vt[3] = '{1'b1, 2'd2, 20, 20, 32'hABCDE, 32'h12345, 32'h00ABCDE0, 32'h00123450};
        vt[4] = '{1'b1, 2'd1, 16, 16, 32'h8001, 32'h7FFE, 32'h00008001, 32'h00007FFE};
        vt[5] = '{1'b0, 2'd3, 32, 32, 32'hDEADBEEF, 32'h01234567, 32'hDEADBEEF, 32'h01234567};
        vt[6] = '{1'b0, 2'd2, 24, 24, 32'h800001, 32'h7FFFFE, 32'h00800001, 32'h007FFFFE};

        do_reset();
        wait_clk(2);
        chk("rst_valid", 64'(rx_valid), 64'd0);
        chk("rst_ldat", 64'(ldat), 64'd0);
        chk("rst_rdat", 64'(rdat), 64'd0);
        chk("rst_cnt", 64'(fcnt), 64'd0);
        chk("rst_sync", 64'(sync), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            fmt = vt[i].f; wdlen = vt[i].wd;
            @(posedge clk); #1 en = 1'b1;
            frame(vt[i].f, vt[i].n, vt[i].dn, vt[i].l, vt[i].r);
            chk($sformatf("v%0d_hunt_sync", i), 64'(sync), 64'd0);
            frame(vt[i].f, vt[i].n, vt[i].dn, vt[i].l, vt[i].r);
            frame(vt[i].f, vt[i].n, vt[i].dn, vt[i].l, vt[i].r);
            slot(1'b0, 1'b0);
            wait_clk(10);
            chk($sformatf("v%0d_sync", i), 64'(sync), 64'd1);
            chk($sformatf("v%0d_cnt", i), 64'(fcnt), 64'd2);
            pop_chk($sformatf("v%0d_p1", i), vt[i].el, vt[i].er);
            pop_chk($sformatf("v%0d_p2", i), vt[i].el, vt[i].er);
            wait_clk(1);
            chk($sformatf("v%0d_empty", i), 64'(rx_valid), 64'd0);
        end

        // Overflow: five completed pairs into a four-deep FIFO with no consumer
        do_reset();
        fmt = 1'b1; wdlen = 2'd1;
        @(posedge clk); #1 en = 1'b1;
        o0 = ovf_total;
        for (int fi = 1; fi <= 6; fi++) frame(1'b1, 16, 16, 32'h1000 + fi, 32'h2000 + fi);
        slot(1'b0, 1'b0);
        wait_clk(10);
        chk("ovf_cnt", 64'(fcnt), 64'd4);
        chk("ovf_pulses", 64'(ovf_total - o0), 64'd1);
        en = 1'b0;
        wait_clk(3);
        chk("ovf_dis_sync", 64'(sync), 64'd0);
        chk("ovf_dis_cnt", 64'(fcnt), 64'd4);
        for (int fi = 2; fi <= 5; fi++)
            pop_chk($sformatf("ovf_drain%0d", fi), 32'h1000 + fi, 32'h2000 + fi);
        wait_clk(1);
        chk("ovf_empty", 64'(rx_valid), 64'd0);
        chk("ovf_empty_ldat", 64'(ldat), 64'd0);

        // Full FIFO with a pop landing on the same cycle as the fifth push
        do_reset();
        fmt = 1'b1; wdlen = 2'd1;
        @(posedge clk); #1 en = 1'b1;
        o0 = ovf_total;
        for (int fi = 1; fi <= 6; fi++) frame(1'b1, 16, 16, 32'h3000 + fi, 32'h4000 + fi);
        chk("sim_full_cnt", 64'(fcnt), 64'd4);
        @(posedge clk); #1 sck = 1'b0; ws = 1'b0; sd = 1'b0;
        repeat (4) @(posedge clk);
        #1 sck = 1'b1;
        repeat (3) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk); #1 ready = 1'b0;
        wait_clk(6);
        chk("sim_cnt", 64'(fcnt), 64'd4);
        chk("sim_no_ovf", 64'(ovf_total - o0), 64'd0);
        en = 1'b0;
        for (int fi = 3; fi <= 6; fi++)
            pop_chk($sformatf("sim_drain%0d", fi), 32'h3000 + fi, 32'h4000 + fi);

        // Enable dropped mid-right, reset mid-left, then realign on the next full frame
        do_reset();
        fmt = 1'b0; wdlen = 2'd1;
        @(posedge clk); #1 en = 1'b1;
        frame(1'b0, 16, 16, 32'h1111, 32'h2222);
        frame_part(1'b0, 16, 16, 32'h3333, 32'h4444, 0, 24);
        @(posedge clk); #1 en = 1'b0;
        frame_part(1'b0, 16, 16, 32'h3333, 32'h4444, 24, 32);
        wait_clk(8);
        chk("en_sync", 64'(sync), 64'd0);
        chk("en_cnt", 64'(fcnt), 64'd0);
        chk("en_valid", 64'(rx_valid), 64'd0);
        frame_part(1'b0, 16, 16, 32'h5555, 32'h6666, 0, 8);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; en = 1'b1;
        chk("mrst_sync", 64'(sync), 64'd0);
        chk("mrst_valid", 64'(rx_valid), 64'd0);
        chk("mrst_ldat", 64'(ldat), 64'd0);
        chk("mrst_cnt", 64'(fcnt), 64'd0);
        frame_part(1'b0, 16, 16, 32'h5555, 32'h6666, 8, 32);
        chk("mrst_hunt_sync", 64'(sync), 64'd0);
        frame(1'b0, 16, 16, 32'hBEEF, 32'hCAFE);
        slot(1'b0, 1'b0);
        wait_clk(10);
        chk("realign_sync", 64'(sync), 64'd1);
        chk("realign_cnt", 64'(fcnt), 64'd1);
        pop_chk("realign", 32'h0000BEEF, 32'h0000CAFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
